// File: rtl/csa_pkg.sv
// Shared FSM state encoding and accumulator width helper for the CSA accumulator.
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Enough headroom that the sum of every term in a full-length operation cannot wrap.
  function automatic int acc_bit_len(input int bit_len, input int terms, input int beats);
    return bit_len + $clog2(terms * beats);
  endfunction

endpackage

// File: rtl/compressor_tree_3_to_2.sv
// Reduces NUM_ELEMENTS operands to a sum/carry pair with a chain of 3:2 carry-save stages.
// Purely combinational; o_sum + o_carry equals the operand total modulo 2^BIT_LEN.
module compressor_tree_3_to_2 #(
  parameter int NUM_ELEMENTS = 3,
  parameter int BIT_LEN      = 16
) (
  input  logic [BIT_LEN-1:0] i_terms [NUM_ELEMENTS],
  output logic [BIT_LEN-1:0] o_sum,
  output logic [BIT_LEN-1:0] o_carry
);

  logic [BIT_LEN-1:0] w_s [NUM_ELEMENTS-1];
  logic [BIT_LEN-1:0] w_c [NUM_ELEMENTS-1];

  assign w_s[0] = i_terms[0];
  assign w_c[0] = i_terms[1];

  // Each stage folds one more operand in; carries shift up and the top bit drops off.
  for (genvar j = 1; j < NUM_ELEMENTS - 1; j++) begin : g_stage
    assign w_s[j] = w_s[j-1] ^ w_c[j-1] ^ i_terms[j+1];
    assign w_c[j] = ((w_s[j-1] & w_c[j-1]) | (w_s[j-1] & i_terms[j+1]) |
                     (w_c[j-1] & i_terms[j+1])) << 1;
  end

  assign o_sum   = w_s[NUM_ELEMENTS-2];
  assign o_carry = w_c[NUM_ELEMENTS-2];

endmodule

// File: rtl/csa_accum_sequencer.sv
// Accumulates num_beats beats of unsigned terms in carry-save form, then resolves one final sum.
// Result appears two edges after the last accepted beat and is held until out_ready.
module csa_accum_sequencer
  import csa_pkg::*;
#(
  parameter int  BIT_LEN        = 16,
  parameter int  TERMS_PER_BEAT = 4,
  parameter int  MAX_BEATS      = 16,
  localparam int ACC_BIT_LEN    = acc_bit_len(BIT_LEN, TERMS_PER_BEAT, MAX_BEATS),
  localparam int NB_W           = $clog2(MAX_BEATS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NB_W-1:0]        num_beats,
  output logic                   busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BIT_LEN-1:0]     in_terms [TERMS_PER_BEAT],
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_BIT_LEN-1:0] out_sum
);

  localparam int NUM_EL = TERMS_PER_BEAT + 2;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ACC_BIT_LEN-1:0] r_c;
  logic [ACC_BIT_LEN-1:0] r_s;
  logic [ACC_BIT_LEN-1:0] r_sum;
  logic [NB_W-1:0]        r_beat_cnt;
  logic [NB_W-1:0]        r_num_beats;
  logic [NB_W-1:0]        w_num_beats_sat;
  logic [NB_W-1:0]        w_cnt_inc;
  logic [ACC_BIT_LEN-1:0] w_tree_in [NUM_EL];
  logic [ACC_BIT_LEN-1:0] w_s_nxt;
  logic [ACC_BIT_LEN-1:0] w_c_nxt;
  logic                   w_beat_acc;
  logic                   w_last_beat;

  assign w_num_beats_sat = (num_beats > NB_W'(MAX_BEATS)) ? NB_W'(MAX_BEATS) : num_beats;
  assign w_cnt_inc       = r_beat_cnt + 1'b1;
  assign w_beat_acc      = in_valid && in_ready;
  assign w_last_beat     = (w_cnt_inc == r_num_beats);

  // Running carry/sum feed back as the first two operands alongside the new terms.
  assign w_tree_in[0] = r_c;
  assign w_tree_in[1] = r_s;
  for (genvar t = 0; t < TERMS_PER_BEAT; t++) begin : g_term
    assign w_tree_in[t+2] = ACC_BIT_LEN'(in_terms[t]);
  end

  compressor_tree_3_to_2 #(
    .NUM_ELEMENTS (NUM_EL),
    .BIT_LEN      (ACC_BIT_LEN)
  ) u_tree (
    .i_terms (w_tree_in),
    .o_sum   (w_s_nxt),
    .o_carry (w_c_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_nxt = (num_beats == '0) ? RESOLVE : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (w_beat_acc && w_last_beat) begin
          w_state_nxt = RESOLVE;
        end
      end
      RESOLVE: w_state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_c         <= '0;
      r_s         <= '0;
      r_sum       <= '0;
      r_beat_cnt  <= '0;
      r_num_beats <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_c         <= '0;
            r_s         <= '0;
            r_beat_cnt  <= '0;
            r_num_beats <= w_num_beats_sat;
          end
        end
        ACCUM: begin
          if (w_beat_acc) begin
            r_c        <= w_c_nxt;
            r_s        <= w_s_nxt;
            r_beat_cnt <= w_cnt_inc;
          end
        end
        RESOLVE: r_sum <= r_c + r_s;
        default: ;
      endcase
    end
  end

  assign out_sum = r_sum;

endmodule

// File: tb/tb_csa_accum_sequencer.sv
// Directed bench: stimulus pushes expected sums into a scoreboard; a monitor pops on each result handshake.
module tb_csa_accum_sequencer;

  localparam int BIT_LEN = 16;
  localparam int TPB     = 4;
  localparam int ACC_W   = 22;
  localparam int NB_W    = 5;

  logic              clk;
  logic              rst;
  logic              start;
  logic [NB_W-1:0]   num_beats;
  logic              busy;
  logic              in_valid;
  logic              in_ready;
  logic [BIT_LEN-1:0] in_terms [TPB];
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;

  int                errors;
  int                checks;
  int                hs_count;
  int                pops;
  logic [ACC_W-1:0]  sb [$];

  csa_accum_sequencer #(
    .BIT_LEN        (BIT_LEN),
    .TERMS_PER_BEAT (TPB),
    .MAX_BEATS      (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_beats (num_beats),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_terms  (in_terms),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Result monitor: compares every output handshake against the scoreboard head.
  initial begin
    logic [ACC_W-1:0] exp;
    forever begin
      @(negedge clk);
      if (!rst && in_valid && in_ready) hs_count++;
      if (!rst && out_valid && out_ready) begin
        pops++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got 0x%0h expected no result", out_sum);
        end else begin
          exp = sb.pop_front();
          chk("out_sum", 32'(out_sum), 32'(exp));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [NB_W-1:0] nb);
    start     = 1'b1;
    num_beats = nb;
    tick();
    start     = 1'b0;
  endtask

  task automatic set_terms(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
    in_terms[0] = a;
    in_terms[1] = b;
    in_terms[2] = c;
    in_terms[3] = d;
  endtask

  task automatic send_beat(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
    int n = 0;
    set_terms(a, b, c, d);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got in_ready=0 expected 1");
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got out_valid=0 expected 1");
    end
    tick();
  endtask

  initial begin
    errors = 0; checks = 0; hs_count = 0; pops = 0;
    rst = 1'b1; start = 1'b0; num_beats = '0; in_valid = 1'b0; out_ready = 1'b1;
    set_terms(16'd0, 16'd0, 16'd0, 16'd0);
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    rst = 1'b0;
    tick();

    // Single beat with exact latency checks.
    sb.push_back(22'd10);
    do_start(5'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_in_ready", 32'(in_ready), 32'd1);
    send_beat(16'd1, 16'd2, 16'd3, 16'd4);
    chk("t1_valid_resolve", 32'(out_valid), 32'd0);
    chk("t1_busy_resolve", 32'(busy), 32'd1);
    tick();
    chk("t1_valid_done", 32'(out_valid), 32'd1);
    tick();
    chk("t1_idle", 32'(busy), 32'd0);

    // Full load with random idle gaps.
    hs_count = 0;
    sb.push_back(22'h3FFFC0);
    do_start(5'd16);
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      send_beat(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    end
    wait_done();
    chk("t2_handshakes", 32'(hs_count), 32'd16);

    // Zero beats goes straight to resolve.
    sb.push_back(22'd0);
    do_start(5'd0);
    chk("t3_in_ready", 32'(in_ready), 32'd0);
    chk("t3_valid_resolve", 32'(out_valid), 32'd0);
    chk("t3_busy", 32'(busy), 32'd1);
    tick();
    chk("t3_valid_done", 32'(out_valid), 32'd1);
    chk("t3_in_ready_done", 32'(in_ready), 32'd0);
    tick();

    // Result backpressure while start is pulsed.
    out_ready = 1'b0;
    sb.push_back(22'd26);
    do_start(5'd1);
    send_beat(16'd5, 16'd6, 16'd7, 16'd8);
    tick();
    for (int i = 0; i < 5; i++) begin
      start     = 1'b1;
      num_beats = 5'd3;
      @(negedge clk);
      chk("t4_valid_held", 32'(out_valid), 32'd1);
      chk("t4_sum_held", 32'(out_sum), 32'd26);
      chk("t4_busy", 32'(busy), 32'd1);
      chk("t4_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_start_ignored_exit", 32'(busy), 32'd0);
    tick();
    chk("t4_still_idle", 32'(busy), 32'd0);

    // Reset in the middle of accumulation.
    do_start(5'd8);
    for (int i = 0; i < 3; i++) send_beat(16'h1234, 16'h1234, 16'h1234, 16'h1234);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd0);
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_out_sum", 32'(out_sum), 32'd0);
    sb.push_back(22'd8);
    do_start(5'd2);
    for (int i = 0; i < 2; i++) send_beat(16'd1, 16'd1, 16'd1, 16'd1);
    wait_done();

    // Oversize beat count saturates.
    hs_count = 0;
    sb.push_back(22'd64);
    do_start(5'd17);
    for (int i = 0; i < 16; i++) send_beat(16'd1, 16'd1, 16'd1, 16'd1);
    chk("t6_in_ready_after16", 32'(in_ready), 32'd0);
    wait_done();
    chk("t6_handshakes", 32'(hs_count), 32'd16);

    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("result_count", 32'(pops), 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
